// File: rtl/effect_sample_bridge_if.sv
// effect_sample_bridge_if
// Bundles the Avalon-MM slave port and the two sample streams of the bridge.
// "master" is the HPS / effect-core side; "slave" is the bridge itself.
interface effect_sample_bridge_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] avs_s0_address;
    logic              avs_s0_write;
    logic [DATA_W-1:0] avs_s0_writedata;
    logic              avs_s0_read;
    logic [DATA_W-1:0] avs_s0_readdata;

    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;

    logic [DATA_W-1:0] snk_data;
    logic              snk_valid;
    logic              snk_ready;

    modport master (
        output avs_s0_address, avs_s0_write, avs_s0_writedata, avs_s0_read,
        input  avs_s0_readdata,
        input  src_data, src_valid,
        output src_ready,
        output snk_data, snk_valid,
        input  snk_ready
    );

    modport slave (
        input  avs_s0_address, avs_s0_write, avs_s0_writedata, avs_s0_read,
        output avs_s0_readdata,
        output src_data, src_valid,
        input  src_ready,
        input  snk_data, snk_valid,
        output snk_ready
    );
endinterface

// File: rtl/effect_sample_bridge.sv
// effect_sample_bridge
// Avalon-MM register bridge between the HPS and the guitar effect core.
// TX FIFO (index 0) carries HPS samples out on the src stream; RX FIFO
// (index 1) collects processed samples from the snk stream for the HPS.
// Optional feature macro: EFFECT_BRIDGE_IRQ_EN adds the IRQ_THRESH register
// (word 0x4) and a level/error interrupt on ins_irq; without it ins_irq is 0.
module effect_sample_bridge #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                  csi_clk,
    input  logic                  reset,
    effect_sample_bridge_if.slave bus,
    output logic                  ins_irq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(3);
`ifdef EFFECT_BRIDGE_IRQ_EN
    localparam logic [ADDR_W-1:0] A_THRESH = ADDR_W'(4);
`endif

    localparam int TX = 0;
    localparam int RX = 1;

    logic              enable_reg;
    logic              tx_ovf_reg;
    logic              rx_unf_reg;
    logic [DATA_W-1:0] readdata_reg;

    logic              fifo_push  [2];
    logic              fifo_pop   [2];
    logic              fifo_empty [2];
    logic              fifo_full  [2];
    logic [DATA_W-1:0] fifo_din   [2];
    logic [DATA_W-1:0] fifo_head  [2];
    logic [LVL_W-1:0]  fifo_level [2];

    logic ctrl_wr, status_wr, flush;
    logic tx_wr_req, rx_rd_req;
    logic tx_ovf_evt, rx_unf_evt;
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] rd_mux;

    // Register decode of the single Avalon access in this cycle
    assign ctrl_wr   = bus.avs_s0_write && (bus.avs_s0_address == A_CTRL);
    assign status_wr = bus.avs_s0_write && (bus.avs_s0_address == A_STATUS);
    assign tx_wr_req = bus.avs_s0_write && (bus.avs_s0_address == A_TXDATA);
    assign rx_rd_req = bus.avs_s0_read  && (bus.avs_s0_address == A_RXDATA);
    assign flush     = ctrl_wr && bus.avs_s0_writedata[1];

    // Stream handshakes; the flush cycle discards every push and pop
    assign bus.src_valid = enable_reg && !fifo_empty[TX];
    assign bus.src_data  = fifo_head[TX];
    assign bus.snk_ready = enable_reg && !fifo_full[RX];

    assign fifo_pop[TX]  = bus.src_valid && bus.src_ready && !flush;
    // A full TX FIFO still takes a write when the head leaves in the same cycle
    assign fifo_push[TX] = tx_wr_req && (!fifo_full[TX] || fifo_pop[TX]) && !flush;
    assign fifo_din[TX]  = bus.avs_s0_writedata;
    assign tx_ovf_evt    = tx_wr_req && fifo_full[TX] && !fifo_pop[TX];

    assign fifo_push[RX] = bus.snk_valid && bus.snk_ready && !flush;
    assign fifo_pop[RX]  = rx_rd_req && !fifo_empty[RX] && !flush;
    assign fifo_din[RX]  = bus.snk_data;
    assign rx_unf_evt    = rx_rd_req && fifo_empty[RX];

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [DATA_W-1:0] mem [DEPTH];
        logic [LVL_W-1:0]  wr_ptr_reg;
        logic [LVL_W-1:0]  rd_ptr_reg;

        // Storage write; entries orphaned by reset or flush are never read
        always_ff @(posedge csi_clk) begin
            if (fifo_push[gi]) begin
                mem[wr_ptr_reg[PTR_W-1:0]] <= fifo_din[gi];
            end
        end

        // Pointers carry one wrap bit so full and empty are distinguishable
        always_ff @(posedge csi_clk) begin
            if (reset || flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (fifo_push[gi]) wr_ptr_reg <= wr_ptr_reg + LVL_W'(1);
                if (fifo_pop[gi])  rd_ptr_reg <= rd_ptr_reg + LVL_W'(1);
            end
        end

        assign fifo_level[gi] = wr_ptr_reg - rd_ptr_reg;
        assign fifo_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
        assign fifo_full[gi]  = (fifo_level[gi] == LVL_W'(DEPTH));
        assign fifo_head[gi]  = mem[rd_ptr_reg[PTR_W-1:0]];
    end

    assign status_word = DATA_W'({rx_unf_reg, tx_ovf_reg, fifo_empty[RX], fifo_full[TX],
                                  8'(fifo_level[RX]), 8'(fifo_level[TX])});

    // ENABLE follows every CTRL write, including the one carrying FLUSH
    always_ff @(posedge csi_clk) begin
        if (reset) begin
            enable_reg <= 1'b0;
        end else if (ctrl_wr) begin
            enable_reg <= bus.avs_s0_writedata[0];
        end
    end

    // Sticky error flags: set on the event, write-1-to-clear, wiped by flush
    always_ff @(posedge csi_clk) begin
        if (reset || flush) begin
            tx_ovf_reg <= 1'b0;
            rx_unf_reg <= 1'b0;
        end else begin
            if (tx_ovf_evt) begin
                tx_ovf_reg <= 1'b1;
            end else if (status_wr && bus.avs_s0_writedata[18]) begin
                tx_ovf_reg <= 1'b0;
            end
            if (rx_unf_evt) begin
                rx_unf_reg <= 1'b1;
            end else if (status_wr && bus.avs_s0_writedata[19]) begin
                rx_unf_reg <= 1'b0;
            end
        end
    end

`ifdef EFFECT_BRIDGE_IRQ_EN
    logic [7:0] irq_thresh_reg;
    logic       irq_reg;

    // RX level threshold; zero disables the level part of the interrupt
    always_ff @(posedge csi_clk) begin
        if (reset) begin
            irq_thresh_reg <= 8'd0;
        end else if (bus.avs_s0_write && (bus.avs_s0_address == A_THRESH)) begin
            irq_thresh_reg <= bus.avs_s0_writedata[7:0];
        end
    end

    // Registered interrupt: RX level at threshold, or any sticky error flag
    always_ff @(posedge csi_clk) begin
        if (reset) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= ((irq_thresh_reg != 8'd0) && (8'(fifo_level[RX]) >= irq_thresh_reg))
                       || tx_ovf_reg || rx_unf_reg;
        end
    end

    assign ins_irq = irq_reg;
`else
    assign ins_irq = 1'b0;
`endif

    // Read mux; RX_DATA on an empty FIFO returns 0
    always_comb begin
        rd_mux = '0;
        case (bus.avs_s0_address)
            A_CTRL:   rd_mux = DATA_W'(enable_reg);
            A_STATUS: rd_mux = status_word;
            A_RXDATA: rd_mux = fifo_empty[RX] ? '0 : fifo_head[RX];
`ifdef EFFECT_BRIDGE_IRQ_EN
            A_THRESH: rd_mux = DATA_W'(irq_thresh_reg);
`endif
            default:  rd_mux = '0;
        endcase
    end

    // Read data is captured once per read and held until the next read
    always_ff @(posedge csi_clk) begin
        if (reset) begin
            readdata_reg <= '0;
        end else if (bus.avs_s0_read) begin
            readdata_reg <= rd_mux;
        end
    end

    assign bus.avs_s0_readdata = readdata_reg;

    // writedata bits with no register behind them
    logic unused_wd;
    assign unused_wd = ^bus.avs_s0_writedata;
endmodule

// File: tb/tb_effect_sample_bridge.sv
// tb_effect_sample_bridge
// Scoreboarded bench: the driver updates a queue-based reference model and
// pushes expected responses; a negedge monitor compares DUT outputs.
// Honours EFFECT_BRIDGE_IRQ_EN when the design is built with it.
module tb_effect_sample_bridge;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    localparam int OP_IDLE  = 0;
    localparam int OP_WRITE = 1;
    localparam int OP_READ  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ins_irq;

    always #5 clk = ~clk;

    effect_sample_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    effect_sample_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .csi_clk (clk),
        .reset   (reset),
        .bus     (bus),
        .ins_irq (ins_irq)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (value seen by the DUT during the current cycle)
    logic [31:0] m_tx[$];
    logic [31:0] m_rx[$];
    bit          m_en, m_ovf, m_unf, m_irq;
    logic [7:0]  m_thr;

    // Scoreboard queues
    logic [31:0] exp_src[$];
    logic [31:0] exp_rd[$];
    logic [2:0]  exp_flags[$];   // {ins_irq, snk_ready, src_valid}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: DUT output with no expected entry", name);
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'd0;
        s[7:0]  = 8'(m_tx.size());
        s[15:8] = 8'(m_rx.size());
        s[16]   = (m_tx.size() == DEPTH);
        s[17]   = (m_rx.size() == 0);
        s[18]   = m_ovf;
        s[19]   = m_unf;
        return s;
    endfunction

    // One clock cycle: drive inputs, record expectations, advance the model
    task automatic cycle(input int op, input logic [3:0] addr, input logic [31:0] wd,
                         input bit sr, input bit sv, input logic [31:0] sd);
        bit e_sv, e_sr, hs_src, hs_snk, fl, irq_nx;
        logic [31:0] rd_exp;
        bus.avs_s0_address   = addr;
        bus.avs_s0_write     = (op == OP_WRITE);
        bus.avs_s0_read      = (op == OP_READ);
        bus.avs_s0_writedata = wd;
        bus.src_ready        = sr;
        bus.snk_valid        = sv;
        bus.snk_data         = sd;

        e_sv = m_en && (m_tx.size() > 0);
        e_sr = m_en && (m_rx.size() < DEPTH);
        exp_flags.push_back({m_irq, e_sr, e_sv});
        hs_src = e_sv && sr;
        hs_snk = e_sr && sv;
        if (hs_src) exp_src.push_back(m_tx[0]);

        if (op == OP_READ) begin
            case (addr)
                4'd0:    rd_exp = {31'd0, m_en};
                4'd1:    rd_exp = m_status();
                4'd3:    rd_exp = (m_rx.size() > 0) ? m_rx[0] : 32'd0;
`ifdef EFFECT_BRIDGE_IRQ_EN
                4'd4:    rd_exp = {24'd0, m_thr};
`endif
                default: rd_exp = 32'd0;
            endcase
            exp_rd.push_back(rd_exp);
        end

`ifdef EFFECT_BRIDGE_IRQ_EN
        irq_nx = ((m_thr != 0) && (m_rx.size() >= int'(m_thr))) || m_ovf || m_unf;
`else
        irq_nx = 1'b0;
`endif

        fl = (op == OP_WRITE) && (addr == 4'd0) && wd[1];
        if (fl) begin
            m_tx.delete();
            m_rx.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_en  = wd[0];
        end else begin
            if (hs_src) void'(m_tx.pop_front());
            if (op == OP_WRITE && addr == 4'd2) begin
                if (m_tx.size() < DEPTH) m_tx.push_back(wd);
                else m_ovf = 1'b1;
            end
            if (op == OP_READ && addr == 4'd3) begin
                if (m_rx.size() > 0) void'(m_rx.pop_front());
                else m_unf = 1'b1;
            end
            if (hs_snk) m_rx.push_back(sd);
            if (op == OP_WRITE && addr == 4'd1) begin
                if (wd[18]) m_ovf = 1'b0;
                if (wd[19]) m_unf = 1'b0;
            end
            if (op == OP_WRITE && addr == 4'd0) m_en = wd[0];
`ifdef EFFECT_BRIDGE_IRQ_EN
            if (op == OP_WRITE && addr == 4'd4) m_thr = wd[7:0];
`endif
        end
        m_irq = irq_nx;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit sr);
        for (int i = 0; i < n; i++) cycle(OP_IDLE, 4'd0, 32'd0, sr, 1'b0, 32'd0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        bus.avs_s0_write = 1'b0;
        bus.avs_s0_read  = 1'b0;
        bus.src_ready    = 1'b0;
        bus.snk_valid    = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        m_tx.delete();
        m_rx.delete();
        exp_src.delete();
        exp_rd.delete();
        exp_flags.delete();
        m_en = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_irq = 1'b0; m_thr = 8'd0;
        check("readdata_after_reset", bus.avs_s0_readdata, 32'd0);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard
    initial begin
        logic [2:0] f;
        bit rd_prev;
        rd_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rd_prev = 1'b0;
            end else begin
                if (rd_prev) begin
                    if (exp_rd.size() == 0) fail_event("readdata");
                    else check("readdata", bus.avs_s0_readdata, exp_rd.pop_front());
                end
                rd_prev = bus.avs_s0_read;
                if (exp_flags.size() > 0) begin
                    f = exp_flags.pop_front();
                    check("src_valid", 32'(bus.src_valid), 32'(f[0]));
                    check("snk_ready", 32'(bus.snk_ready), 32'(f[1]));
                    check("ins_irq",   32'(ins_irq),       32'(f[2]));
                end
                if (bus.src_valid && bus.src_ready) begin
                    if (exp_src.size() == 0) fail_event("src_data");
                    else check("src_data", bus.src_data, exp_src.pop_front());
                end
            end
        end
    end

    initial begin
        int w_tx, w_rx, p_sr, p_sv, r;
        logic [31:0] wd;
        bus.avs_s0_address   = '0;
        bus.avs_s0_write     = 1'b0;
        bus.avs_s0_read      = 1'b0;
        bus.avs_s0_writedata = '0;
        bus.src_ready        = 1'b0;
        bus.snk_valid        = 1'b0;
        bus.snk_data         = '0;
        @(posedge clk);
        #1;
        do_reset(3);

        // Reset state through STATUS
        cycle(OP_READ, 4'd1, 32'd0, 1'b0, 1'b0, 32'd0);
        idle(1, 1'b0);

        // Single sample through the source
        cycle(OP_WRITE, 4'd0, 32'd1, 1'b1, 1'b0, 32'd0);
        cycle(OP_WRITE, 4'd2, 32'hC130_0000, 1'b1, 1'b0, 32'd0);
        idle(1, 1'b1);
        cycle(OP_READ, 4'd1, 32'd0, 1'b0, 1'b0, 32'd0);

        // Overfill TX, then clear the overflow flag
        for (int i = 0; i < 17; i++)
            cycle(OP_WRITE, 4'd2, 32'h1000_0000 + 32'(i), 1'b0, 1'b0, 32'd0);
        cycle(OP_READ, 4'd1, 32'd0, 1'b0, 1'b0, 32'd0);
        cycle(OP_WRITE, 4'd1, 32'h0004_0000, 1'b0, 1'b0, 32'd0);
        cycle(OP_READ, 4'd1, 32'd0, 1'b0, 1'b0, 32'd0);

        // Full TX: write together with a source handshake, then drain in order
        cycle(OP_WRITE, 4'd2, 32'hABCD_0000, 1'b1, 1'b0, 32'd0);
        cycle(OP_READ, 4'd1, 32'd0, 1'b0, 1'b0, 32'd0);
        idle(18, 1'b1);

        // RX path and underflow
        cycle(OP_IDLE, 4'd0, 32'd0, 1'b0, 1'b1, 32'h3F80_0000);
        cycle(OP_IDLE, 4'd0, 32'd0, 1'b0, 1'b1, 32'h4000_0000);
        for (int i = 0; i < 3; i++) cycle(OP_READ, 4'd3, 32'd0, 1'b0, 1'b0, 32'd0);
        cycle(OP_READ, 4'd1, 32'd0, 1'b0, 1'b0, 32'd0);
        cycle(OP_WRITE, 4'd1, 32'h000C_0000, 1'b0, 1'b0, 32'd0);

        // Threshold interrupt and flush
        cycle(OP_WRITE, 4'd4, 32'd2, 1'b0, 1'b0, 32'd0);
        cycle(OP_READ, 4'd4, 32'd0, 1'b0, 1'b0, 32'd0);
        cycle(OP_IDLE, 4'd0, 32'd0, 1'b0, 1'b1, 32'h1111_1111);
        cycle(OP_IDLE, 4'd0, 32'd0, 1'b0, 1'b1, 32'h2222_2222);
        idle(2, 1'b0);
        cycle(OP_READ, 4'd3, 32'd0, 1'b0, 1'b0, 32'd0);
        idle(2, 1'b0);
        cycle(OP_IDLE, 4'd0, 32'd0, 1'b0, 1'b1, 32'h3333_3333);
        cycle(OP_WRITE, 4'd2, 32'h4444_4444, 1'b0, 1'b0, 32'd0);
        cycle(OP_WRITE, 4'd0, 32'h3, 1'b0, 1'b0, 32'd0);
        cycle(OP_READ, 4'd1, 32'd0, 1'b0, 1'b0, 32'd0);
        idle(2, 1'b0);

        // Reset in the middle of traffic discards FIFO contents
        for (int i = 0; i < 5; i++)
            cycle(OP_WRITE, 4'd2, 32'h5500_0000 + 32'(i), 1'b0, 1'b1, 32'h6600_0000 + 32'(i));
        do_reset(2);
        cycle(OP_READ, 4'd1, 32'd0, 1'b1, 1'b0, 32'd0);
        cycle(OP_READ, 4'd3, 32'd0, 1'b1, 1'b0, 32'd0);
        cycle(OP_WRITE, 4'd0, 32'd1, 1'b1, 1'b0, 32'd0);

        // Randomized phases with varying pressure on each FIFO
        for (int ph = 0; ph < 40; ph++) begin
            w_tx = $urandom_range(5, 45);
            w_rx = $urandom_range(5, 45);
            p_sr = $urandom_range(0, 100);
            p_sv = $urandom_range(0, 100);
            for (int k = 0; k < 64; k++) begin
                bit sr, sv;
                sr = ($urandom_range(0, 99) < p_sr);
                sv = ($urandom_range(0, 99) < p_sv);
                r  = $urandom_range(0, 99);
                wd = $urandom;
                if (r < w_tx) begin
                    cycle(OP_WRITE, 4'd2, wd, sr, sv, $urandom);
                end else if (r < w_tx + w_rx) begin
                    cycle(OP_READ, 4'd3, wd, sr, sv, $urandom);
                end else if (r < w_tx + w_rx + 5) begin
                    cycle(OP_READ, 4'd1, wd, sr, sv, $urandom);
                end else if (r < w_tx + w_rx + 7) begin
                    cycle(OP_WRITE, 4'd1, wd, sr, sv, $urandom);
                end else if (r < w_tx + w_rx + 9) begin
                    wd[0] = ($urandom_range(0, 7) != 0);
                    wd[1] = ($urandom_range(0, 5) == 0);
                    cycle(OP_WRITE, 4'd0, wd, sr, sv, $urandom);
                end else if (r < w_tx + w_rx + 10) begin
                    cycle(OP_READ, 4'd0, wd, sr, sv, $urandom);
                end else if (r < w_tx + w_rx + 12) begin
                    wd[7:0] = 8'($urandom_range(0, 6));
                    cycle($urandom_range(0, 1) ? OP_WRITE : OP_READ, 4'd4, wd, sr, sv, $urandom);
                end else if (r < w_tx + w_rx + 14) begin
                    cycle($urandom_range(0, 1) ? OP_WRITE : OP_READ,
                          4'($urandom_range(5, 15)), wd, sr, sv, $urandom);
                end else if (r < w_tx + w_rx + 15) begin
                    cycle(OP_READ, 4'd2, wd, sr, sv, $urandom);
                end else begin
                    cycle(OP_IDLE, 4'd0, wd, sr, sv, $urandom);
                end
            end
        end
        idle(3, 1'b0);

        check("src_pending", 32'(exp_src.size()), 32'd0);
        check("rd_pending",  32'(exp_rd.size()),  32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
